// File: rtl/uart_receiver.sv
// 8-bit UART receiver, 8N1 framing, LSB first, with mid-bit sampling from a bit-period counter.
// Defining PARITY_EN adds a parity bit (8E1/8O1 via PARITY_ODD) and the parity_error port.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 2604,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_error,
`ifdef PARITY_EN
  output logic       parity_error,
`endif
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_error_q, frame_error_d;
  logic             parity_error_q, parity_error_d;
  logic             sync1_q, rx_s_q, rx_prev_q;
  logic             half_tick, full_tick, fall_edge, parity_bad;

`ifdef PARITY_EN
  logic             par_q, par_d;

  function automatic logic expected_parity(input logic [7:0] d);
    return (^d) ^ PARITY_ODD;
  endfunction
`endif

  // Stage p0: two-flop synchroniser plus edge-history flop, all idling high
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= rx;
      rx_s_q    <= sync1_q;
      rx_prev_q <= rx_s_q;
    end
  end

  assign fall_edge = rx_prev_q & ~rx_s_q;
  assign half_tick = (cnt_q == CNT_HALF);
  assign full_tick = (cnt_q == CNT_FULL);

  // Stage p1: framing state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (fall_edge) state_d = S_START;
      S_START:  if (half_tick) state_d = rx_s_q ? S_IDLE : S_DATA;
      S_DATA: begin
        if (full_tick && bit_idx_q == 3'd7) begin
`ifdef PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
      S_PARITY: if (full_tick) state_d = S_STOP;
      S_STOP:   if (full_tick) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

`ifdef PARITY_EN
  assign parity_bad = (par_q != expected_parity(shreg_q));
`else
  // Without a parity bit the parity sense has no effect.
  assign parity_bad = PARITY_ODD & 1'b0;
`endif

  always_comb begin
    cnt_d          = cnt_q;
    bit_idx_d      = bit_idx_q;
    shreg_d        = shreg_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    frame_error_d  = 1'b0;
    parity_error_d = 1'b0;
`ifdef PARITY_EN
    par_d          = par_q;
`endif
    if (state_d != state_q || state_q == S_IDLE || full_tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    case (state_q)
      S_START: bit_idx_d = 3'd0;
      S_DATA: begin
        if (full_tick) begin
          shreg_d   = {rx_s_q, shreg_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
        end
      end
`ifdef PARITY_EN
      S_PARITY: if (full_tick) par_d = rx_s_q;
`endif
      S_STOP: begin
        if (full_tick) begin
          frame_error_d  = ~rx_s_q;
          parity_error_d = parity_bad;
          rx_valid_d     = rx_s_q & ~parity_bad;
          if (rx_s_q && !parity_bad) rx_data_d = shreg_q;
        end
      end
      default: ;
    endcase
  end

  // Stage p2: counters and registered result pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q          <= '0;
      bit_idx_q      <= 3'd0;
      rx_data_q      <= 8'd0;
      rx_valid_q     <= 1'b0;
      frame_error_q  <= 1'b0;
      parity_error_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      bit_idx_q      <= bit_idx_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      frame_error_q  <= frame_error_d;
      parity_error_q <= parity_error_d;
    end
  end

  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
`ifdef PARITY_EN
    par_q   <= par_d;
`endif
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_error = frame_error_q;
  assign busy        = (state_q != S_IDLE);
`ifdef PARITY_EN
  assign parity_error = parity_error_q;
`else
  logic unused_parity_error;
  assign unused_parity_error = parity_error_q;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at CLKS_PER_BIT=16; result pulses are checked against a
// scoreboard queue filled as frames are driven. The parity step runs only when PARITY_EN is defined.
module tb_uart_receiver;
  localparam int CPB     = 16;
  localparam bit PAR_ODD = 1'b0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_error, busy, perr;
  logic       par_flip = 1'b0;

`ifdef PARITY_EN
  logic parity_error;
  assign perr = parity_error;
`else
  assign perr = 1'b0;
`endif

  uart_receiver #(.CLKS_PER_BIT(CPB), .PARITY_ODD(PAR_ODD)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .frame_error (frame_error),
`ifdef PARITY_EN
    .parity_error(parity_error),
`endif
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] flags;  // {parity_error, frame_error, rx_valid}
    logic [7:0] data;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  tests = 0;
  int  fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_ev(input logic [2:0] flags, input logic [7:0] data);
    exp_q.push_back('{flags: flags, data: data});
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef PARITY_EN
    send_bit((^d) ^ PAR_ODD ^ par_flip);
`endif
    send_bit(stop_bit);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 * CPB && exp_q.size() != 0; i++) @(negedge clk);
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard: every result pulse must match the oldest expected event
  always @(negedge clk) begin
    if (!rst && (rx_valid || frame_error || perr)) begin
      check("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("pulse_flags", 32'({perr, frame_error, rx_valid}), 32'(mon_e.flags));
        check("pulse_data", 32'(rx_data), 32'(mon_e.data));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_rx_data", 32'(rx_data), 32'h0);
    check("rst_rx_valid", 32'(rx_valid), 32'h0);
    check("rst_frame_error", 32'(frame_error), 32'h0);
    check("rst_parity_error", 32'(perr), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single frame 0xA5
    expect_ev(3'b001, 8'hA5);
    send_frame(8'hA5, 1'b1);
    drain("t1");
    check("t1_busy_after", 32'(busy), 32'h0);
    check("t1_rx_data", 32'(rx_data), 32'hA5);
    check("t1_frame_error", 32'(frame_error), 32'h0);
    send_bit(1'b1);

    // Back-to-back frames, no idle gap
    expect_ev(3'b001, 8'h00);
    expect_ev(3'b001, 8'hFF);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    drain("t2");
    check("t2_rx_data", 32'(rx_data), 32'hFF);
    send_bit(1'b1);

    // Start-bit glitch
    rx = 1'b0;
    repeat (4) @(negedge clk);
    check("t3_busy_during_glitch", 32'(busy), 32'h1);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("t3_busy_after_glitch", 32'(busy), 32'h0);
    check("t3_rx_data_kept", 32'(rx_data), 32'hFF);

    // Low stop bit then break: one frame_error, no retrigger
    expect_ev(3'b010, 8'hFF);
    send_frame(8'h3C, 1'b0);
    repeat (40) @(negedge clk);
    check("t4_no_retrigger", 32'(busy), 32'h0);
    drain("t4");
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("t4_busy_idle", 32'(busy), 32'h0);
    check("t4_rx_data_kept", 32'(rx_data), 32'hFF);

    // Reset during data bit 3 of a 0x0F frame
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    rx = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    check("t5_busy_midframe", 32'(busy), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_rst_rx_data", 32'(rx_data), 32'h0);
    check("t5_rst_rx_valid", 32'(rx_valid), 32'h0);
    check("t5_rst_frame_error", 32'(frame_error), 32'h0);
    check("t5_rst_parity_error", 32'(perr), 32'h0);
    check("t5_rst_busy", 32'(busy), 32'h0);
    repeat (2 * CPB) @(negedge clk);
    check("t5_idle_after_rst", 32'(busy), 32'h0);
    expect_ev(3'b001, 8'h5A);
    send_frame(8'h5A, 1'b1);
    drain("t5");
    check("t5_rx_data", 32'(rx_data), 32'h5A);
    send_bit(1'b1);

`ifdef PARITY_EN
    // Even parity: 0x07 with parity 1 is good, with parity 0 is a parity error
    expect_ev(3'b001, 8'h07);
    send_frame(8'h07, 1'b1);
    drain("t6_good");
    send_bit(1'b1);
    par_flip = 1'b1;
    expect_ev(3'b100, 8'h07);
    send_frame(8'h07, 1'b1);
    par_flip = 1'b0;
    drain("t6_bad");
    check("t6_rx_data_kept", 32'(rx_data), 32'h07);
`endif

    repeat (2 * CPB) @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
